// File: rtl/dcount_timer_if.sv
// Control/status bundle for dcount_timer: load/clear/enable/mode in, count/busy/tc out.
interface dcount_timer_if #(
    parameter int W = 4
);
    logic         clr;
    logic         load;
    logic [W-1:0] d;
    logic         en;
    logic         auto_rl;
    logic [W-1:0] q;
    logic         busy;
    logic         tc;

    modport master (
        output clr, load, d, en, auto_rl,
        input  q, busy, tc
    );

    modport slave (
        input  clr, load, d, en, auto_rl,
        output q, busy, tc
    );
endinterface

// File: rtl/dcount_timer.sv
// Loadable down-counter/timer with one-shot/auto-reload and a one-cycle tc pulse; optional tick prescaler under DCOUNT_PRESCALE_EN.
// Latency: load of N with en high gives tc N cycles after the load edge (N*PRESCALE with the prescaler).
// Backpressure: none; en low holds the count, clr > load > count priority.
module dcount_timer #(
    parameter int W        = 4,
    parameter int PRESCALE = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dcount_timer_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_q;
    logic [W-1:0] w_q_nxt;
    logic [W-1:0] r_rl;
    logic [W-1:0] w_rl_nxt;
    logic         r_tc;
    logic         w_tc_nxt;
    logic         w_tick;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("dcount_timer: PRESCALE must be >= 1");
    end

`ifdef DCOUNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] r_ps;
    logic [PW-1:0] w_ps_nxt;
    logic          w_ps_wrap;

    assign w_ps_wrap = (r_ps == PW'(PRESCALE - 1));
    assign w_tick    = (r_state == RUN) && bus.en && w_ps_wrap;

    // Prescaler restarts on any clear/load so every new count gets a full first period.
    always_comb begin
        w_ps_nxt = r_ps;
        if (bus.clr || bus.load) begin
            w_ps_nxt = '0;
        end else if ((r_state == RUN) && bus.en) begin
            w_ps_nxt = w_ps_wrap ? '0 : r_ps + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ps <= '0;
        end else begin
            r_ps <= w_ps_nxt;
        end
    end
`else
    assign w_tick = (r_state == RUN) && bus.en;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_rl_nxt    = r_rl;
        w_tc_nxt    = 1'b0;
        if (bus.clr) begin
            w_q_nxt     = '0;
            w_state_nxt = IDLE;
        end else if (bus.load) begin
            w_q_nxt     = bus.d;
            w_rl_nxt    = bus.d;
            w_state_nxt = (bus.d != '0) ? RUN : IDLE;
        end else if (w_tick) begin
            // RUN guarantees r_q >= 1, so the decrement never wraps below zero.
            if (r_q == W'(1)) begin
                w_tc_nxt = 1'b1;
                if (bus.auto_rl) begin
                    w_q_nxt = r_rl;
                end else begin
                    w_q_nxt     = '0;
                    w_state_nxt = IDLE;
                end
            end else begin
                w_q_nxt = r_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_rl    <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_rl    <= w_rl_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign bus.q    = r_q;
    assign bus.busy = (r_state == RUN);
    assign bus.tc   = r_tc;

endmodule

// File: tb/tb_dcount_timer.sv
// Self-checking bench for dcount_timer: per-cycle model comparison plus directed literal expectations.
module tb_dcount_timer;

    localparam int W        = 4;
    localparam int PRESCALE = 4;
`ifdef DCOUNT_PRESCALE_EN
    localparam int PS_MULT = PRESCALE;
`else
    localparam int PS_MULT = 1;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    dcount_timer_if #(.W(W)) bus ();

    dcount_timer #(
        .W        (W),
        .PRESCALE (PRESCALE)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining count, reload value, running flag, tc pulse, prescale phase.
    int m_q;
    int m_rl;
    int m_run;
    int m_tc;
    int m_ps;
    int m_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = 0; m_rl = 0; m_run = 0; m_tc = 0; m_ps = 0;
        end else if (bus.clr) begin
            m_q = 0; m_run = 0; m_tc = 0; m_ps = 0;
        end else if (bus.load) begin
            m_q   = int'(bus.d);
            m_rl  = int'(bus.d);
            m_run = (bus.d != 0) ? 1 : 0;
            m_tc  = 0;
            m_ps  = 0;
        end else if (m_run == 1 && bus.en) begin
            m_tick = 1;
`ifdef DCOUNT_PRESCALE_EN
            m_ps = m_ps + 1;
            if (m_ps == PRESCALE) m_ps = 0;
            else m_tick = 0;
`endif
            m_tc = 0;
            if (m_tick == 1) begin
                if (m_q - 1 == 0) begin
                    m_tc = 1;
                    if (bus.auto_rl) m_q = m_rl;
                    else begin m_q = 0; m_run = 0; end
                end else begin
                    m_q = m_q - 1;
                end
            end
        end else begin
            m_tc = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_q",    int'(bus.q),    m_q);
            chk("model_busy", int'(bus.busy), m_run);
            chk("model_tc",   int'(bus.tc),   m_tc);
        end
    end

    task automatic step(input logic c, input logic l, input logic [W-1:0] dv,
                        input logic e, input logic a);
        bus.clr     = c;
        bus.load    = l;
        bus.d       = dv;
        bus.en      = e;
        bus.auto_rl = a;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string name, input int q, input int busy, input int tc);
        chk({name, "_q"},    int'(bus.q),    q);
        chk({name, "_busy"}, int'(bus.busy), busy);
        chk({name, "_tc"},   int'(bus.tc),   tc);
    endtask

    int lat;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n       = 1'b0;
        bus.clr     = 1'b0;
        bus.load    = 1'b0;
        bus.d       = '0;
        bus.en      = 1'b0;
        bus.auto_rl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect3("reset", 0, 0, 0);
        rst_n = 1'b1;

        // Asynchronous reset mid-count, no clock edge involved.
        step(0, 1, 5, 1, 0);
        expect3("load5", 5, 1, 0);
        #1 rst_n = 1'b0;
        #1 expect3("async_rst", 0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 1, 0);
        expect3("post_rst_idle", 0, 0, 0);

`ifndef DCOUNT_PRESCALE_EN
        // One-shot count of 3.
        step(0, 1, 3, 1, 0); expect3("os_3", 3, 1, 0);
        step(0, 0, 0, 1, 0); expect3("os_2", 2, 1, 0);
        step(0, 0, 0, 1, 0); expect3("os_1", 1, 1, 0);
        step(0, 0, 0, 1, 0); expect3("os_0", 0, 0, 1);
        step(0, 0, 0, 1, 0); expect3("os_hold", 0, 0, 0);

        // Auto-reload, period 2.
        step(0, 1, 2, 1, 1); expect3("ar_load", 2, 1, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 1);
            expect3("ar2", (i % 2 == 0) ? 1 : 2, 1, (i % 2 == 0) ? 0 : 1);
        end
        step(0, 1, 1, 1, 1); expect3("ar1_load", 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 1);
            expect3("ar1", 1, 1, 1);
        end

        // Enable gating.
        step(0, 1, 4, 0, 0); expect3("en_load", 4, 1, 0);
        step(0, 0, 0, 1, 0); expect3("en_1", 3, 1, 0);
        step(0, 0, 0, 0, 0); expect3("en_0", 3, 1, 0);
        step(0, 0, 0, 1, 0); expect3("en_1b", 2, 1, 0);

        // Reload at q==1 pre-empts the terminal event.
        step(0, 1, 2, 1, 0);
        step(0, 0, 0, 1, 0); expect3("pre_q1", 1, 1, 0);
        step(0, 1, 9, 1, 0); expect3("load_at_q1", 9, 1, 0);
`endif

        // clr beats load.
        step(1, 1, 7, 1, 0); expect3("clr_load", 0, 0, 0);

        // Zero load never runs, never fires.
        step(0, 1, 0, 1, 1); expect3("load0", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 1);
            expect3("load0_hold", 0, 0, 0);
        end

        // Full-range load latency.
        step(0, 1, 15, 1, 0);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            step(0, 0, 0, 1, 0);
            if (bus.tc) begin lat = i; break; end
        end
        chk("lat15", lat, 15 * PS_MULT);

`ifdef DCOUNT_PRESCALE_EN
        step(0, 1, 2, 1, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        chk("ps_q_hold", int'(bus.q), 2);
        step(0, 0, 0, 1, 0);
        chk("ps_q_dec", int'(bus.q), 1);
        step(1, 0, 0, 1, 0);
        step(0, 1, 2, 1, 0);
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            step(0, 0, 0, 1, 0);
            if (bus.tc) begin lat = i; break; end
        end
        chk("ps_lat2", lat, 2 * PRESCALE);
`endif

        step(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
